gen_grf: RTL and testbench
==========================

Name: gen_grf

Overview:
- Parametrised general-purpose register file; successor of the fixed 32x32, 2-read/1-write GRF.
- Generalises data width, depth and read-port count.
- Adds a second write port for the multi-cycle unit (MDU/late-completion path) and a per-register busy scoreboard.
- Sits in the ID stage: read ports serve operand fetch; write port 0 is driven by W-stage writeback; write port 1 by the late-completion unit.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- we0  in  1  write enable, port 0 (writeback).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (late completion).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- busy_set  in  1  mark register pending (issue of a multi-cycle op).
- busy_addr  in  ADDR_W  register to mark pending.
- ra  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  per-read-port flag: addressed register is pending.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): all registers cleared to 0, all busy bits cleared. rd and rd_busy are combinational, so they read 0 while reset is held.
- Write commit:
  - On posedge, a port commits when weN=1 and, if ZERO_REG=1, waN!=0.
  - Both ports may commit distinct addresses in the same cycle.
  - Same address on both ports in the same cycle: port 0 data is stored, port 1 data is dropped.
- Read:
  - Combinational, zero latency.
  - ZERO_REG=1 and address 0: returns 0 regardless of writes.
  - Otherwise returns the stored value, or the bypass value per Optional Feature.
- Scoreboard:
  - One busy bit per register.
  - Set on posedge when busy_set=1 (ignored for address 0 if ZERO_REG=1).
  - Cleared on posedge when port 1 commits to that address.
  - Port 0 writes never clear busy.
  - Set and port 1 clear on the same address in the same cycle: set wins (bit stays 1).
  - Set on an already-busy register: no change.
  - rd_busy[k] = busy[ra_k] registered value, ORed with busy_set && busy_addr==ra_k in the same cycle, so issue-to-read is stall-safe.
  - A port 1 write in the current cycle does not deassert rd_busy until the next cycle, even with bypass enabled.
- Reset mid-operation: pending busy bits and in-flight writes are discarded; a write edge coincident with reset assertion is lost.
- No X propagation: out-of-range addresses are impossible by width.

Optional Feature:
- Macro: GEN_GRF_BYPASS_EN.
- Defined: internal write-to-read forwarding. For read port k, if port 0 commits to ra_k this cycle, rd_k = wd0. Else if port 1 commits to ra_k, rd_k = wd1. Port 0 has priority, matching the storage rule.
- Undefined: rd_k always returns the stored array value. Same-cycle writes are visible only from the next cycle; the pipeline must forward externally.

Decomposition:
- Package gen_grf_pkg holds:
  - default constants GRF_DATA_W=32 and GRF_ADDR_W=5;
  - constant GRF_ZERO_ADDR=0;
  - typedef grf_addr_t and grf_data_t for the default configuration.
- Sub-module grf_read_port, one instance per read port via a generate loop. It takes one address, the storage, busy vector, both write-port controls and busy_set, and produces one rd slice and one rd_busy bit, including the bypass mux under the macro.
- Storage, write priority and scoreboard logic stay in gen_grf.

Test Plan:
- Reset: write 0xDEADBEEF to r5 via port 0, then pulse reset=0 asynchronously mid-cycle -> rd for ra=5 is 0x00000000 immediately; all rd_busy=0.
- Zero register: we0=1, wa0=0, wd0=0x12345678 -> ra=0 reads 0 same cycle and next cycle; busy_set on r0 -> rd_busy stays 0.
- Dual-write conflict: same cycle we0 wa0=7 wd0=0xAAAA0000 and we1 wa1=7 wd1=0x5555FFFF -> next cycle r7 reads 0xAAAA0000; we0 wa0=3 wd0=0x11 with we1 wa1=4 wd1=0x22 -> r3=0x11, r4=0x22.
- Bypass: with GEN_GRF_BYPASS_EN, we0 wa0=9 wd0=0xCAFEF00D and ra0=9 -> rd0=0xCAFEF00D same cycle. Without the macro -> rd0 equals the old r9 value that cycle and 0xCAFEF00D next cycle.
- Scoreboard: busy_set busy_addr=12 with ra1=12 -> rd_busy[1]=1 same cycle and after. A we0 to r12 leaves it busy. A we1 wa1=12 wd1=0x77 -> rd_busy[1]=1 that cycle, 0 next; r12=0x77.
- Set/clear collision: r12 busy; same cycle busy_set addr=12 and we1 wa1=12 -> r12 updated, busy remains 1. Repeat with NUM_RD=4 and DATA_W=16 to check slicing on all four ports.

Source files
------------

// File: rtl/gen_grf_pkg.sv
// gen_grf_pkg: shared constants and types for the generic register file.
//   GRF_DATA_W / GRF_ADDR_W : default register width and address width
//   GRF_ZERO_ADDR           : index of the hardwired-zero register
//   grf_addr_t / grf_data_t : address and data types for the default config
package gen_grf_pkg;

    localparam int GRF_DATA_W    = 32;
    localparam int GRF_ADDR_W    = 5;
    localparam int GRF_ZERO_ADDR = 0;

    typedef logic [GRF_ADDR_W-1:0] grf_addr_t;
    typedef logic [GRF_DATA_W-1:0] grf_data_t;

endpackage

// File: rtl/gen_grf_read_port.sv
// grf_read_port: one combinational operand-fetch port of gen_grf.
// Optional feature: GEN_GRF_BYPASS_EN enables same-cycle write-to-read forwarding.
// Ports:
//   ra        in   read address
//   mem       in   register storage (all registers)
//   busy      in   scoreboard vector (one bit per register)
//   fwd0/1    in   write port 0/1 commits this cycle (already reset-gated)
//   wa0/1     in   write addresses, wd0/1 write data
//   mark      in   busy_set this cycle (already zero-reg and reset gated)
//   mark_addr in   register being marked
//   rd        out  read data
//   rd_busy   out  addressed register is pending
module grf_read_port
    import gen_grf_pkg::*;
#(
    parameter int DATA_W   = GRF_DATA_W,
    parameter int ADDR_W   = GRF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]                    ra,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   mem,
    input  logic [(2**ADDR_W)-1:0]               busy,
    input  logic                                 fwd0,
    input  logic [ADDR_W-1:0]                    wa0,
    input  logic [DATA_W-1:0]                    wd0,
    input  logic                                 fwd1,
    input  logic [ADDR_W-1:0]                    wa1,
    input  logic [DATA_W-1:0]                    wd1,
    input  logic                                 mark,
    input  logic [ADDR_W-1:0]                    mark_addr,
    output logic [DATA_W-1:0]                    rd,
    output logic                                 rd_busy
);

    logic is_zero;

    assign is_zero = (ZERO_REG != 0) && (ra == ADDR_W'(GRF_ZERO_ADDR));

    // An issue in this cycle already counts as busy so a dependent read stalls.
    assign rd_busy = busy[ra] | (mark && (mark_addr == ra));

`ifdef GEN_GRF_BYPASS_EN
    // Port 0 wins over port 1, matching which data ends up in storage.
    always_comb begin
        rd = mem[ra];
        if (is_zero)
            rd = '0;
        else if (fwd0 && (wa0 == ra))
            rd = wd0;
        else if (fwd1 && (wa1 == ra))
            rd = wd1;
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{fwd0, wa0, wd0, fwd1, wa1, wd1};

    always_comb begin
        rd = mem[ra];
        if (is_zero)
            rd = '0;
    end
`endif

endmodule

// File: rtl/gen_grf.sv
// gen_grf: parametrised register file with two write ports and a busy scoreboard.
// Optional feature: GEN_GRF_BYPASS_EN enables same-cycle write-to-read forwarding.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   we0/wa0/wd0 in  write port 0 (writeback)
//   we1/wa1/wd1 in  write port 1 (late completion, also clears busy)
//   busy_set   in   mark busy_addr pending
//   busy_addr  in   register to mark pending
//   ra         in   NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd         out  NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy    out  per-read-port pending flag
module gen_grf
    import gen_grf_pkg::*;
#(
    parameter int DATA_W   = GRF_DATA_W,
    parameter int ADDR_W   = GRF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       busy_set,
    input  logic [ADDR_W-1:0]          busy_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rd_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic                         commit0;
    logic                         commit1;
    logic                         mark;
    logic                         fwd0;
    logic                         fwd1;
    logic                         mark_vis;

    // The zero register is never written and never marked busy.
    always_comb begin
        commit0 = we0;
        commit1 = we1;
        mark    = busy_set;
        if (ZERO_REG != 0) begin
            if (wa0 == ADDR_W'(GRF_ZERO_ADDR))
                commit0 = 1'b0;
            if (wa1 == ADDR_W'(GRF_ZERO_ADDR))
                commit1 = 1'b0;
            if (busy_addr == ADDR_W'(GRF_ZERO_ADDR))
                mark = 1'b0;
        end
    end

    // Read-side copies are masked while reset is held so rd/rd_busy show 0;
    // kept separate from the storage path so reset stays purely asynchronous there.
    assign fwd0     = commit0 & reset;
    assign fwd1     = commit1 & reset;
    assign mark_vis = mark & reset;

    // Port 0 is applied last so it overwrites port 1 on an address clash.
    // Likewise the busy set is applied after the port 1 clear so set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            if (commit1)
                mem[wa1] <= wd1;
            if (commit0)
                mem[wa0] <= wd0;
            if (commit1)
                busy[wa1] <= 1'b0;
            if (mark)
                busy[busy_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        grf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .ra        (ra[k*ADDR_W +: ADDR_W]),
            .mem       (mem),
            .busy      (busy),
            .fwd0      (fwd0),
            .wa0       (wa0),
            .wd0       (wd0),
            .fwd1      (fwd1),
            .wa1       (wa1),
            .wd1       (wd1),
            .mark      (mark_vis),
            .mark_addr (busy_addr),
            .rd        (rd[k*DATA_W +: DATA_W]),
            .rd_busy   (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_gen_grf.sv
// tb_gen_grf: directed table-driven bench for gen_grf (default 2-port build)
// plus a 4-port, 16-bit instance for slice ordering.
// Works with or without GEN_GRF_BYPASS_EN defined.
module tb_gen_grf;
    import gen_grf_pkg::*;

`ifdef GEN_GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    typedef struct {
        logic       we0;
        grf_addr_t  wa0;
        grf_data_t  wd0;
        logic       we1;
        grf_addr_t  wa1;
        grf_data_t  wd1;
        logic       bs;
        grf_addr_t  ba;
        grf_addr_t  ra0;
        grf_addr_t  ra1;
        grf_data_t  exp_rd0;
        grf_data_t  exp_rd1;
        logic [1:0] exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        we0, we1, busy_set;
    grf_addr_t   wa0, wa1, busy_addr;
    grf_data_t   wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;

    logic        p4_we0, p4_we1, p4_busy_set;
    logic [4:0]  p4_wa0, p4_wa1, p4_busy_addr;
    logic [15:0] p4_wd0, p4_wd1;
    logic [19:0] p4_ra;
    logic [63:0] p4_rd;
    logic [3:0]  p4_rd_busy;

    int vec_count  = 0;
    int miss_count = 0;

    vec_t vecs[19];

    always #5 clk = ~clk;

    gen_grf dut (
        .clk       (clk),
        .reset     (reset),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy)
    );

    gen_grf #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .we0       (p4_we0),
        .wa0       (p4_wa0),
        .wd0       (p4_wd0),
        .we1       (p4_we1),
        .wa1       (p4_wa1),
        .wd1       (p4_wd1),
        .busy_set  (p4_busy_set),
        .busy_addr (p4_busy_addr),
        .ra        (p4_ra),
        .rd        (p4_rd),
        .rd_busy   (p4_rd_busy)
    );

    function automatic vec_t mv(input logic a_we0, input grf_addr_t a_wa0, input grf_data_t a_wd0,
                                input logic a_we1, input grf_addr_t a_wa1, input grf_data_t a_wd1,
                                input logic a_bs, input grf_addr_t a_ba,
                                input grf_addr_t a_ra0, input grf_addr_t a_ra1,
                                input grf_data_t e0, input grf_data_t e1, input logic [1:0] eb);
        vec_t v;
        v.we0 = a_we0; v.wa0 = a_wa0; v.wd0 = a_wd0;
        v.we1 = a_we1; v.wa1 = a_wa1; v.wd1 = a_wd1;
        v.bs = a_bs; v.ba = a_ba; v.ra0 = a_ra0; v.ra1 = a_ra1;
        v.exp_rd0 = e0; v.exp_rd1 = e1; v.exp_busy = eb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        busy_set = v.bs; busy_addr = v.ba;
        ra = {v.ra1, v.ra0};
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idleAll();
        we0 = N; wa0 = 5'd0; wd0 = 32'h0; we1 = N; wa1 = 5'd0; wd1 = 32'h0;
        busy_set = N; busy_addr = 5'd0; ra = 10'd0;
        p4_we0 = N; p4_wa0 = 5'd0; p4_wd0 = 16'h0; p4_we1 = N; p4_wa1 = 5'd0; p4_wd1 = 16'h0;
        p4_busy_set = N; p4_busy_addr = 5'd0; p4_ra = 20'd0;
    endtask

    initial begin
        vecs[0]  = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd0,  5'd5,  32'h0, 32'h0, 2'b00);
        vecs[1]  = mv(Y, 5'd0,  32'h12345678, N, 5'd0,  32'h0,        Y, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 2'b00);
        vecs[2]  = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 2'b00);
        vecs[3]  = mv(Y, 5'd7,  32'hAAAA0000, Y, 5'd7,  32'h5555FFFF, N, 5'd0,  5'd7,  5'd3,  BYP ? 32'hAAAA0000 : 32'h0, 32'h0, 2'b00);
        vecs[4]  = mv(Y, 5'd3,  32'h11,       Y, 5'd4,  32'h22,       N, 5'd0,  5'd7,  5'd3,  32'hAAAA0000, BYP ? 32'h11 : 32'h0, 2'b00);
        vecs[5]  = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd3,  5'd4,  32'h11, 32'h22, 2'b00);
        vecs[6]  = mv(Y, 5'd9,  32'hCAFEF00D, N, 5'd0,  32'h0,        N, 5'd0,  5'd9,  5'd7,  BYP ? 32'hCAFEF00D : 32'h0, 32'hAAAA0000, 2'b00);
        vecs[7]  = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd9,  5'd0,  32'hCAFEF00D, 32'h0, 2'b00);
        vecs[8]  = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        Y, 5'd12, 5'd9,  5'd12, 32'hCAFEF00D, 32'h0, 2'b10);
        vecs[9]  = mv(Y, 5'd12, 32'h1234,     N, 5'd0,  32'h0,        N, 5'd0,  5'd9,  5'd12, 32'hCAFEF00D, BYP ? 32'h1234 : 32'h0, 2'b10);
        vecs[10] = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd9,  5'd12, 32'hCAFEF00D, 32'h1234, 2'b10);
        vecs[11] = mv(N, 5'd0,  32'h0,        Y, 5'd12, 32'h77,       N, 5'd0,  5'd9,  5'd12, 32'hCAFEF00D, BYP ? 32'h77 : 32'h1234, 2'b10);
        vecs[12] = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd9,  5'd12, 32'hCAFEF00D, 32'h77, 2'b00);
        vecs[13] = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        Y, 5'd12, 5'd9,  5'd12, 32'hCAFEF00D, 32'h77, 2'b10);
        vecs[14] = mv(N, 5'd0,  32'h0,        Y, 5'd12, 32'h99,       Y, 5'd12, 5'd9,  5'd12, 32'hCAFEF00D, BYP ? 32'h99 : 32'h77, 2'b10);
        vecs[15] = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd12, 5'd12, 32'h99, 32'h99, 2'b11);
        vecs[16] = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        Y, 5'd12, 5'd12, 5'd4,  32'h99, 32'h22, 2'b01);
        vecs[17] = mv(N, 5'd0,  32'h0,        Y, 5'd12, 32'h5,        N, 5'd0,  5'd12, 5'd4,  BYP ? 32'h5 : 32'h99, 32'h22, 2'b01);
        vecs[18] = mv(N, 5'd0,  32'h0,        N, 5'd0,  32'h0,        N, 5'd0,  5'd12, 5'd4,  32'h5, 32'h22, 2'b00);

        // Power-on reset held, outputs must read zero without any clock edge mattering.
        idleAll();
        ra = {5'd5, 5'd5};
        reset = 1'b0;
        #2;
        checkOutput("reset_rd", rd, 64'h0);
        checkOutput("reset_busy", 64'(rd_busy), 64'h0);
        #10 reset = 1'b1;

        // Main table: inputs applied after negedge, outputs sampled before next posedge.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_rd0", i), 64'(rd[31:0]), 64'(vecs[i].exp_rd0));
            checkOutput($sformatf("v%0d_rd1", i), 64'(rd[63:32]), 64'(vecs[i].exp_rd1));
            checkOutput($sformatf("v%0d_busy", i), 64'(rd_busy), 64'(vecs[i].exp_busy));
        end

        // Asynchronous reset in the middle of a cycle with state and busy bits present.
        @(negedge clk);
        idleAll();
        we0 = Y; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        busy_set = Y; busy_addr = 5'd6;
        ra = {5'd6, 5'd5};
        @(negedge clk);
        we0 = N; busy_set = N;
        #1;
        checkOutput("pre_reset_r5", 64'(rd[31:0]), 64'hDEADBEEF);
        checkOutput("pre_reset_busy6", 64'(rd_busy), 64'b10);
        busy_set = Y;
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_r5", 64'(rd[31:0]), 64'h0);
        checkOutput("midreset_busy", 64'(rd_busy), 64'h0);
        @(negedge clk);
        busy_set = N;
        reset = 1'b1;
        #1;
        checkOutput("post_reset_r5", 64'(rd[31:0]), 64'h0);
        checkOutput("post_reset_busy", 64'(rd_busy), 64'h0);

        // Four-port, 16-bit instance: slice ordering and set/clear collision.
        p4_ra = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        checkOutput("p4_reset_rd", p4_rd, 64'h0);
        @(negedge clk);
        p4_we0 = Y; p4_wa0 = 5'd1; p4_wd0 = 16'h1111;
        p4_we1 = Y; p4_wa1 = 5'd2; p4_wd1 = 16'h2222;
        p4_busy_set = Y; p4_busy_addr = 5'd3;
        @(negedge clk);
        p4_busy_set = N;
        p4_wa0 = 5'd3; p4_wd0 = 16'h3333;
        p4_wa1 = 5'd4; p4_wd1 = 16'h4444;
        @(negedge clk);
        p4_we0 = N; p4_we1 = N;
        #1;
        checkOutput("p4_rd_fwd", p4_rd, 64'h4444_3333_2222_1111);
        checkOutput("p4_busy_fwd", 64'(p4_rd_busy), 64'b0100);
        p4_busy_set = Y; p4_busy_addr = 5'd3;
        p4_we1 = Y; p4_wa1 = 5'd3; p4_wd1 = 16'hABCD;
        @(negedge clk);
        p4_busy_set = N; p4_we1 = N;
        #1;
        checkOutput("p4_collide_rd", p4_rd, 64'h4444_ABCD_2222_1111);
        checkOutput("p4_collide_busy", 64'(p4_rd_busy), 64'b0100);
        p4_ra = {5'd1, 5'd2, 5'd3, 5'd4};
        #1;
        checkOutput("p4_rev_rd", p4_rd, 64'h1111_2222_ABCD_4444);
        checkOutput("p4_rev_busy", 64'(p4_rd_busy), 64'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
